// File: rtl/or3_vec_sequencer.sv
// or3_vec_sequencer: clocked stimulus/response stage for an N-input OR gate.
// Walks every input vector, holds each for HOLD_CYCLES edges, samples y_in on
// the last edge of the hold window and compares it against the expected OR.
// Reports pass/fail, the mismatch count and the first failing vector.
//
// Optional feature: define OR3SEQ_STOP_ON_FAIL_EN to end the run on the first
// mismatch instead of walking all 2**WIDTH vectors.
module or3_vec_sequencer #(
    parameter int unsigned WIDTH       = 3,
    parameter int unsigned HOLD_CYCLES = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] vec,
    output logic             vec_valid,
    input  logic             y_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH:0]   err_cnt,
    output logic [WIDTH-1:0] first_fail_vec
);

    // Hold counter runs HOLD_CYCLES-1 down to 0; the edge seen at 0 is the check edge.
    localparam int unsigned CntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CntW-1:0]  HoldLast = CntW'(HOLD_CYCLES - 1);
    localparam logic [WIDTH-1:0] VecLast  = '1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] vec_q, vec_d;
    logic             vec_valid_q, vec_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [WIDTH:0]   err_cnt_q, err_cnt_d;
    logic [WIDTH-1:0] ffv_q, ffv_d;
    logic [CntW-1:0]  hold_q, hold_d;

    logic check_edge;
    logic mismatch;
    logic finish;

    assign check_edge = (hold_q == '0);
    assign mismatch   = (y_in != (|vec_q));

`ifdef OR3SEQ_STOP_ON_FAIL_EN
    assign finish = (vec_q == VecLast) || mismatch;
`else
    assign finish = (vec_q == VecLast);
`endif

    // State and registered outputs; reset aborts any run asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            vec_q       <= '0;
            vec_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            ffv_q       <= '0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            vec_valid_q <= vec_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_cnt_q   <= err_cnt_d;
            ffv_q       <= ffv_d;
            hold_q      <= hold_d;
        end
    end

    // Next-state: start handling, hold countdown, compare/advance, end of run.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        vec_valid_d = vec_valid_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_cnt_d   = err_cnt_q;
        ffv_d       = ffv_q;
        hold_d      = hold_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d     = StRun;
                    vec_d       = '0;
                    vec_valid_d = 1'b1;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    err_cnt_d   = '0;
                    ffv_d       = '0;
                    hold_d      = HoldLast;
                end
            end
            StRun: begin
                if (!check_edge) begin
                    hold_d = hold_q - 1'b1;
                end else begin
                    hold_d = HoldLast;
                    vec_d  = vec_q + 1'b1;
                    if (mismatch) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                        // First mismatch of the run is the one seen while the count is still 0.
                        if (err_cnt_q == '0) begin
                            ffv_d = vec_q;
                        end
                    end
                    if (finish) begin
                        state_d     = StDone;
                        vec_d       = '0;
                        vec_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                        pass_d      = (err_cnt_d == '0);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign vec            = vec_q;
    assign vec_valid      = vec_valid_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_cnt        = err_cnt_q;
    assign first_fail_vec = ffv_q;

endmodule

// File: doc/or3_vec_sequencer.md
# or3_vec_sequencer

Self-checking stimulus/response stage for the 3-input OR gate (`orgate`).
- Upstream role: it drives every input combination onto `a`, `b`, `c`.
- Downstream role: it samples `y` and compares it against the expected OR.
- It replaces the hand-written `#5` vector lists with a clocked, reusable sequencer that reports pass/fail and the error count.

## Interface
Parameters:
- `WIDTH`, default 3: number of gate inputs; `2**WIDTH` vectors per run.
- `HOLD_CYCLES`, default 5: cycles each vector is held before `y` is sampled; legal range ≥1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level-sampled start request; acted on only in IDLE or DONE.
- `vec`  out  WIDTH  applied vector; `vec[WIDTH-1]` drives `a`, `vec[0]` drives the last input (`c`).
- `vec_valid`  out  1  high while `vec` is being driven in RUN.
- `y_in`  in  1  gate output under test.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `pass`  out  1  valid in DONE; 1 iff `err_cnt == 0`.
- `err_cnt`  out  WIDTH+1  number of mismatching vectors in the current/last run; saturation never needed (max `2**WIDTH`).
- `first_fail_vec`  out  WIDTH  vector of the first mismatch; 0 if none.

## Operation
- **States:** IDLE, RUN, DONE; all outputs registered.
- **Reset** (asynchronous, any state): state=IDLE, `vec`=0, `vec_valid`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `first_fail_vec`=0, hold counter=0.
- **IDLE/DONE + `start`=1 at an edge:**
  - Go to RUN with `vec`=0 and `vec_valid`=1.
  - Clear `err_cnt`, `first_fail_vec`, `pass` and `done`.
  - Reload the hold counter.
- **RUN:**
  - The hold counter counts `HOLD_CYCLES` edges.
  - On the final edge, `y_in` is compared with `|vec`.
  - On a mismatch, `err_cnt`+1. If this is the first mismatch of the run, `first_fail_vec` takes the current `vec`.
  - On that same edge, `vec` increments.
- **End of run:** the edge that checks vector all-ones moves the FSM to DONE. `vec` returns to 0, `vec_valid`=0, `busy`=0, `done`=1, and `pass` = (updated `err_cnt`==0).
- **DONE:** results are held indefinitely until `start` or reset.
- **Boundary conditions:**
  - `start` during RUN is ignored.
  - `vec` wrap from all-ones never occurs inside RUN.
  - A mismatch on the last vector is counted before `pass` is computed.

## Timing
- `start` sampled at edge T0; vector n is driven from edge T0+n·HOLD_CYCLES.
- Vector n is checked at edge T0+(n+1)·HOLD_CYCLES.
- `done` rises at edge T0+2**WIDTH·HOLD_CYCLES. With the defaults this is T0+40.
- `y_in` must be settled by the sampling edge; the gate path is combinational, so `HOLD_CYCLES`=1 is legal.
- Reset mid-RUN aborts immediately (asynchronously). A fresh `start` is required after `rst_n` deasserts.

## Configuration
- Macro: `OR3SEQ_STOP_ON_FAIL_EN`.
- **Defined:**
  - The first mismatch ends the run on that edge: go to DONE with `err_cnt`=1 and `pass`=0.
  - `first_fail_vec` holds the failing vector.
  - `vec` returns to 0.
- **Undefined:** all `2**WIDTH` vectors always run; `err_cnt` reflects total mismatches.

## Test plan
- **Correct OR model, defaults:** `start` pulse -> `vec` walks 0..7 every 5 cycles; `done`=1 exactly 40 cycles after `start`; `err_cnt`=0, `pass`=1, `first_fail_vec`=0.
- **Stuck-at-0 model (`y_in`=0):** -> `err_cnt`=7, `first_fail_vec`=3'b001, `pass`=0.
- **Model `y`=`a` only (`vec[2]`):** -> mismatches on 001, 010, 011; `err_cnt`=3, `first_fail_vec`=3'b001.
- **Reset and restart:**
  - Drop `rst_n` at cycle 17 of a run -> all outputs 0 immediately.
  - Release `rst_n`, then pulse `start` -> a full run completes in 40 cycles with correct results.
- **Start interactions:**
  - `start` held high throughout RUN -> no restart.
  - `start` in DONE -> counters cleared and a new run begins at the next edge.
  - `HOLD_CYCLES`=1 -> `done` after 8 cycles.
- **With `OR3SEQ_STOP_ON_FAIL_EN` defined, stuck-at-1 model:** -> stops at vector 0 after 5 cycles; `done`=1, `err_cnt`=1, `first_fail_vec`=0, `pass`=0.
